pos_order_accum: RTL

- Sequential order-total engine for the POS display path.
- Holds a writable price table and per-item quantity counters for NUM_ITEMS menu entries, and recomputes the order total by scanning items one per cycle.
- Drives a registered total, overflow flag and line count to the LCD UI layer.
- Generalises fixed-price, select-only summation to arbitrary item count, quantities, runtime prices, add/remove and saturation.

---
 rtl/pos_order_accum.sv | 136 +++++++++++++
 1 files changed

// File: rtl/pos_order_accum.sv
// Order-total engine: writable price table plus per-item quantity counters,
// rescanned one item per cycle after every accepted change to produce a saturated total.
module pos_order_accum #(
  parameter int NUM_ITEMS = 8,
  parameter int PRICE_W   = 16,
  parameter int QTY_W     = 4,
  parameter int TOTAL_W   = 20,
  localparam int IDX_W    = $clog2(NUM_ITEMS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               price_we,
  input  logic [IDX_W-1:0]   price_addr,
  input  logic [PRICE_W-1:0] price_data,
  input  logic               item_valid,
  input  logic [IDX_W-1:0]   item_idx,
  input  logic               item_remove,
  input  logic               clear,
  output logic [TOTAL_W-1:0] total,
  output logic               total_valid,
  output logic               total_ovf,
  output logic               busy,
  output logic [IDX_W:0]     num_lines,
  output logic               qty_sat
);

  localparam int PROD_W = QTY_W + PRICE_W;
  localparam int SUM_W  = ((PROD_W > TOTAL_W) ? PROD_W : TOTAL_W) + 1;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  logic [PRICE_W-1:0] r_price [NUM_ITEMS];
  logic [QTY_W-1:0]   r_qty   [NUM_ITEMS];
  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [TOTAL_W-1:0] r_acc;
  logic               r_acc_ovf;
  logic [IDX_W:0]     r_lines;
  logic [TOTAL_W-1:0] r_total;
  logic               r_total_valid;
  logic               r_total_ovf;
  logic [IDX_W:0]     r_num_lines;
  logic               r_qty_sat;

  logic               w_price_ok;
  logic               w_item_ok;
  logic               w_change;
  logic [QTY_W-1:0]   w_qty_cur;
  logic [PROD_W-1:0]  w_prod;
  logic [SUM_W-1:0]   w_sum;
  logic               w_sum_ovf;
  logic [TOTAL_W-1:0] w_acc_next;
  logic               w_last;

  assign w_price_ok = price_we && ({1'b0, price_addr} < (IDX_W+1)'(NUM_ITEMS));
  assign w_item_ok  = item_valid && ({1'b0, item_idx} < (IDX_W+1)'(NUM_ITEMS));
  assign w_change   = w_price_ok || w_item_ok || clear;
  assign w_qty_cur  = r_qty[item_idx];

  // Once the sticky overflow is set the accumulator is pinned at all-ones.
  assign w_prod     = PROD_W'(r_qty[r_idx]) * PROD_W'(r_price[r_idx]);
  assign w_sum      = SUM_W'(r_acc) + SUM_W'(w_prod);
  assign w_sum_ovf  = |w_sum[SUM_W-1:TOTAL_W];
  assign w_acc_next = (r_acc_ovf || w_sum_ovf) ? '1 : w_sum[TOTAL_W-1:0];
  assign w_last     = (r_idx == IDX_W'(NUM_ITEMS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
        r_price[i] <= '0;
        r_qty[i]   <= '0;
      end
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_acc         <= '0;
      r_acc_ovf     <= 1'b0;
      r_lines       <= '0;
      r_total       <= '0;
      r_total_valid <= 1'b1;
      r_total_ovf   <= 1'b0;
      r_num_lines   <= '0;
      r_qty_sat     <= 1'b0;
    end else begin
      r_qty_sat <= 1'b0;
      if (w_price_ok) r_price[price_addr] <= price_data;

      // Clear wins over a same-cycle item event; price writes are independent.
      if (clear) begin
        for (int unsigned i = 0; i < NUM_ITEMS; i++) r_qty[i] <= '0;
      end else if (w_item_ok) begin
        if (item_remove) begin
          if (w_qty_cur == '0) r_qty_sat <= 1'b1;
          else                 r_qty[item_idx] <= w_qty_cur - QTY_W'(1);
        end else begin
          if (w_qty_cur == '1) r_qty_sat <= 1'b1;
          else                 r_qty[item_idx] <= w_qty_cur + QTY_W'(1);
        end
      end

      if (w_change) begin
        r_state       <= S_SCAN;
        r_idx         <= '0;
        r_acc         <= '0;
        r_acc_ovf     <= 1'b0;
        r_lines       <= '0;
        r_total_valid <= 1'b0;
      end else begin
        case (r_state)
          S_SCAN: begin
            r_acc     <= w_acc_next;
            r_acc_ovf <= r_acc_ovf || w_sum_ovf;
            if (r_qty[r_idx] != '0) r_lines <= r_lines + (IDX_W+1)'(1);
            r_idx     <= r_idx + IDX_W'(1);
            if (w_last) r_state <= S_DONE;
          end
          S_DONE: begin
            r_total       <= r_acc;
            r_total_ovf   <= r_acc_ovf;
            r_num_lines   <= r_lines;
            r_total_valid <= 1'b1;
            r_state       <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign total       = r_total;
  assign total_valid = r_total_valid;
  assign total_ovf   = r_total_ovf;
  assign busy        = (r_state != S_IDLE);
  assign num_lines   = r_num_lines;
  assign qty_sat     = r_qty_sat;

endmodule
